// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the bit-serial add/sub unit.
// Optional SLT support is controlled by SERIAL_ADDSUB_SLT_EN.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SLT = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Sub and SLT both run a + ~b + 1; everything else is a plain add.
  function automatic logic op_inverts_b(input logic [1:0] op);
`ifdef SERIAL_ADDSUB_SLT_EN
    return (op == OP_SUB) || (op == OP_SLT);
`else
    return (op == OP_SUB);
`endif
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full adder used as the datapath cell of serial_addsub.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  always_comb begin
    p    = a ^ b;
    sum  = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit, one bit per clock, LSB first, with valid/ready handshakes.
// Defining SERIAL_ADDSUB_SLT_EN makes op=10 a set-less-than; otherwise op=10 adds.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  logic fa_a, fa_b, fa_sum, fa_cout;
  logic ovf;

  full_adder_1b u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    fa_a = a_q[cnt_q];
    fa_b = b_q[cnt_q] ^ op_inverts_b(op_q);
    // On the MSB cycle carry_q is the carry into the MSB.
    ovf  = carry_q ^ fa_cout;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          carry_d = op_inverts_b(op);
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[cnt_q] = fa_sum;
        carry_d      = fa_cout;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d    = StDone;
          result_d   = sum_d;
          carryout_d = fa_cout;
          overflow_d = ovf;
`ifdef SERIAL_ADDSUB_SLT_EN
          if (op_q == OP_SLT) begin
            result_d = {{(WIDTH - 1){1'b0}}, fa_sum ^ ovf};
          end
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;

endmodule
